mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the riscv-pipeline EX stage. Implements the RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), generalised to XLEN.
- Sits beside the combinational ALU; the pipeline stalls on ready/valid handshakes.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; must be a power of 2 and ≥8.
- CNT_W, $clog2(XLEN), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- req_valid_mdu_i  in  1  operation request
- req_ready_mdu_o  out  1  unit can accept; high only in IDLE
- op_mdu_i  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- opr_a_mdu_i  in  XLEN  rs1 / dividend
- opr_b_mdu_i  in  XLEN  rs2 / divisor
- kill_mdu_i  in  1  flush; aborts any in-flight op
- res_valid_mdu_o  out  1  result available
- res_ready_mdu_i  in  1  consumer takes result
- res_mdu_o  out  XLEN  result
- dz_mdu_o  out  1  divide-by-zero flag; valid with res_valid_mdu_o

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on port reset.
- Reset values:
  - state=IDLE, req_ready_mdu_o=1, res_valid_mdu_o=0, res_mdu_o=0, dz_mdu_o=0, counter=0.
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - On req_valid & req_ready, latch op and operands.
  - Signed ops take |a| and |b| and record the result sign:
    - MUL*: sign = sa^sb.
    - DIV: sign = sa^sb.
    - REM: sign = sa.
    - MULHSU treats b as unsigned.
  - Counter loads XLEN-1; next state is BUSY.
- BUSY: one iteration per cycle; the counter decrements; on counter==0 at the clock edge, go to FIX.
  - Multiply: 2*XLEN accumulator; add multiplicand if the LSB of the multiplier is 1, then shift right.
  - Divide: shift the remainder left, bring in the next dividend bit, trial-subtract the divisor, keep the result if non-negative, set the quotient bit.
- FIX (1 cycle):
  - Apply the two's-complement sign correction.
  - Select the low half (MUL), high half (MULH*), quotient (DIV*) or remainder (REM*).
  - Register res_mdu_o; next state is DONE.
- DONE:
  - res_valid_mdu_o=1; res_mdu_o and dz_mdu_o are held stable until res_ready_mdu_i=1.
  - Then go to IDLE; res_valid_mdu_o is low and req_ready_mdu_o is high in the following cycle.
- Latency: accept at edge 0 → res_valid_mdu_o high in cycle XLEN+2 (34 for XLEN=32). Throughput is one op per XLEN+3 cycles minimum.
- Divide by zero (b==0):
  - Quotient is all-ones and remainder is the dividend, for both signed and unsigned. This falls out of the restoring algorithm without sign correction on the quotient.
  - dz_mdu_o=1.
- Signed overflow (DIV/REM, a=most-negative, b=-1): quotient is the most-negative value, remainder is 0. No flag.
- req_valid while not IDLE: ignored; no queueing.
- kill_mdu_i in any state: next state is IDLE and res_valid_mdu_o drops next cycle. kill has priority over accept and over result handshake in the same cycle.
- Async reset mid-operation: immediate return to reset values; no partial result is visible.

Optional Feature:
- MDU_EARLY_OUT_EN defined:
  - Accepted ops with b==0 (DIV*/REM*), signed overflow, or either operand zero (MUL*) skip BUSY/FIX.
  - The result is registered at the accept edge; the state goes straight to DONE, so res_valid_mdu_o is high in cycle 1.
- Undefined: all ops take the full XLEN+2 latency. Results are identical either way.

Decomposition:
- Shared define header riscv_mdu_defines.v holds:
  - the op encodings MUL_OP..REMU_OP;
  - the state encodings;
  - MDU_EARLY_OUT_EN documentation.
- One natural sub-module: mdu_negate (XLEN-wide conditional two's-complement), instanced for operand abs and result fix.
- The control FSM and datapath stay in mdu_iter.

Test Plan:
- MUL 7 × 0xFFFFFFFD → res 0xFFFFFFEB, res_valid first high cycle 34 after accept. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM 0xFFFFFFF9/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 7/0 → 0xFFFFFFFF with dz=1; REM 7/0 → 7 with dz=1; DIV 0x80000000/0xFFFFFFFF → 0x80000000 with dz=0; REM of the same operands → 0.
- Backpressure:
  - Hold res_ready low 5 cycles in DONE → res/dz stable, req_ready low, new req_valid ignored.
  - Raise res_ready → req_ready high next cycle, and a back-to-back op completes correctly.
- Abort:
  - kill at BUSY cycle 10 → IDLE next cycle, no res_valid, and the next op is correct.
  - Assert reset mid-BUSY → outputs at reset values in the same cycle.
- MDU_EARLY_OUT_EN:
  - DIVU 7/0 → res_valid in cycle 1 with the macro defined, cycle 34 without; results are equal.
  - MUL 0×5 → cycle 1 with the macro defined.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_iter_pkg : op/state encodings and operand-sign helpers       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mdu_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] MUL_OP    = 3'b000;
  localparam logic [2:0] MULH_OP   = 3'b001;
  localparam logic [2:0] MULHSU_OP = 3'b010;
  localparam logic [2:0] MULHU_OP  = 3'b011;
  localparam logic [2:0] DIV_OP    = 3'b100;
  localparam logic [2:0] DIVU_OP   = 3'b101;
  localparam logic [2:0] REM_OP    = 3'b110;
  localparam logic [2:0] REMU_OP   = 3'b111;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MUL_OP) || (op == MULH_OP) || (op == MULHSU_OP) ||
           (op == DIV_OP) || (op == REM_OP);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MUL_OP) || (op == MULH_OP) || (op == DIV_OP) || (op == REM_OP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_iter_if : request/result handshake bundle of the MDU         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mdu_iter_if #(
  parameter int XLEN = 32
);
  logic            req_valid_mdu_i;
  logic            req_ready_mdu_o;
  logic [2:0]      op_mdu_i;
  logic [XLEN-1:0] opr_a_mdu_i;
  logic [XLEN-1:0] opr_b_mdu_i;
  logic            kill_mdu_i;
  logic            res_valid_mdu_o;
  logic            res_ready_mdu_i;
  logic [XLEN-1:0] res_mdu_o;
  logic            dz_mdu_o;

  modport master (
    output req_valid_mdu_i, op_mdu_i, opr_a_mdu_i, opr_b_mdu_i, kill_mdu_i, res_ready_mdu_i,
    input  req_ready_mdu_o, res_valid_mdu_o, res_mdu_o, dz_mdu_o
  );

  modport slave (
    input  req_valid_mdu_i, op_mdu_i, opr_a_mdu_i, opr_b_mdu_i, kill_mdu_i, res_ready_mdu_i,
    output req_ready_mdu_o, res_valid_mdu_o, res_mdu_o, dz_mdu_o
  );
endinterface
`default_nettype wire

// File: rtl/mdu_negate.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_negate : conditional two's-complement of a W-bit value       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mdu_negate #(
  parameter int W = 32
) (
  input  wire logic [W-1:0] i_val,
  input  wire logic         i_neg,
  output logic      [W-1:0] o_val
);
  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;
endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_iter : iterative RV32M-style multiply/divide, 1 bit / cycle  |
// | Optional macro MDU_EARLY_OUT_EN: trivial ops finish at accept.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic clk,
  input  wire logic reset,
  mdu_iter_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_op;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opb;
  logic                r_neg;
  logic                r_dz;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_res;

  logic                w_accept;
  logic                w_sa;
  logic                w_sb;
  logic                w_b_zero;
  logic                w_is_div;
  logic                w_neg_in;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic                w_early;
  logic [XLEN-1:0]     w_early_res;

  assign w_accept = bus.req_valid_mdu_i && (r_state == ST_IDLE) && !bus.kill_mdu_i;
  assign w_is_div = bus.op_mdu_i[2];
  assign w_b_zero = (bus.opr_b_mdu_i == '0);
  assign w_sa     = op_a_signed(bus.op_mdu_i) && bus.opr_a_mdu_i[XLEN-1];
  assign w_sb     = op_b_signed(bus.op_mdu_i) && bus.opr_b_mdu_i[XLEN-1];

  // A zero divisor must leave the quotient all-ones, so its sign fix is suppressed.
  always_comb begin
    w_neg_in = w_sa ^ w_sb;
    if (w_is_div) begin
      if (bus.op_mdu_i[1]) w_neg_in = w_sa;
      else                 w_neg_in = (w_sa ^ w_sb) && !w_b_zero;
    end
  end

  mdu_negate #(.W(XLEN)) u_abs_a (.i_val(bus.opr_a_mdu_i), .i_neg(w_sa), .o_val(w_abs_a));
  mdu_negate #(.W(XLEN)) u_abs_b (.i_val(bus.opr_b_mdu_i), .i_neg(w_sb), .o_val(w_abs_b));

`ifdef MDU_EARLY_OUT_EN
  logic w_ovf;
  assign w_ovf = w_is_div && !bus.op_mdu_i[0] &&
                 (bus.opr_a_mdu_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (bus.opr_b_mdu_i == {XLEN{1'b1}});
  assign w_early = w_is_div ? (w_b_zero || w_ovf)
                            : (w_b_zero || (bus.opr_a_mdu_i == '0));
  always_comb begin
    w_early_res = '0;
    if (w_is_div) begin
      if (bus.op_mdu_i[1]) w_early_res = w_b_zero ? bus.opr_a_mdu_i : '0;
      else                 w_early_res = w_b_zero ? {XLEN{1'b1}} : {1'b1, {(XLEN-1){1'b0}}};
    end
  end
`else
  assign w_early     = 1'b0;
  assign w_early_res = '0;
`endif

  // Multiply step: accumulate multiplicand into the high half, shift right with carry.
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_nxt;
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide step: acc holds {remainder, remaining dividend bits / quotient bits}.
  logic [XLEN:0]       w_div_sh;
  logic                w_div_ge;
  logic [XLEN-1:0]     w_div_rem;
  logic [2*XLEN-1:0]   w_div_nxt;
  assign w_div_sh  = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_ge  = (w_div_sh >= {1'b0, r_opb});
  assign w_div_rem = w_div_ge ? (w_div_sh[XLEN-1:0] - r_opb) : w_div_sh[XLEN-1:0];
  assign w_div_nxt = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};

  logic [2*XLEN-1:0]   w_fix_src;
  logic [2*XLEN-1:0]   w_fix_val;
  logic [XLEN-1:0]     w_fix_res;
  assign w_fix_src = r_op[2] ? {{XLEN{1'b0}}, (r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0])}
                             : r_acc;
  mdu_negate #(.W(2*XLEN)) u_fix (.i_val(w_fix_src), .i_neg(r_neg), .o_val(w_fix_val));
  assign w_fix_res = (!r_op[2] && (r_op[1:0] != 2'b00)) ? w_fix_val[2*XLEN-1:XLEN]
                                                       : w_fix_val[XLEN-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_early ? ST_DONE : ST_BUSY;
      ST_BUSY: if (r_cnt == '0) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: if (bus.res_ready_mdu_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.kill_mdu_i) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op  <= '0;
      r_acc <= '0;
      r_opb <= '0;
      r_neg <= 1'b0;
      r_dz  <= 1'b0;
      r_cnt <= '0;
      r_res <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op  <= bus.op_mdu_i;
          r_opb <= w_is_div ? w_abs_b : w_abs_a;
          r_acc <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
          r_neg <= w_neg_in;
          r_dz  <= w_is_div && w_b_zero;
          r_cnt <= CNT_W'(XLEN-1);
          if (w_early) r_res <= w_early_res;
        end
        ST_BUSY: begin
          r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        ST_FIX:  r_res <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign bus.req_ready_mdu_o = (r_state == ST_IDLE);
  assign bus.res_valid_mdu_o = (r_state == ST_DONE);
  assign bus.res_mdu_o       = r_res;
  assign bus.dz_mdu_o        = r_dz;

endmodule
`default_nettype wire
